// File: rtl/softmax_row_stream.sv
// rtl/softmax_row_stream.sv - buffered per-row softmax: max, exp/sum, one reciprocal, normalise to 0..127
// Optional macro SOFTMAX_TEMP_SCALE_EN adds cfg_shift, arithmetic-shifting (x - max) right before the exp LUT.
module softmax_row_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 64,
  parameter int EXP_WIDTH  = 16,
  parameter int SUM_WIDTH  = 32,
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int CW = $clog2(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LW-1:0]         cfg_len,
  input  logic                  cfg_causal,
  input  logic [CW-1:0]         cfg_row,
`ifdef SOFTMAX_TEMP_SCALE_EN
  input  logic [2:0]            cfg_shift,
`endif
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]         out_col,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  row_done
);

  localparam int PW     = EXP_WIDTH + SUM_WIDTH;
  localparam int DIV_CW = $clog2(SUM_WIDTH);
  localparam logic [SUM_WIDTH-1:0] DIVIDEND   = SUM_WIDTH'(127) << 24;
  localparam logic [PW-1:0]        ROUND_HALF = PW'(1) << 23;

  typedef enum logic [2:0] {IDLE, LOAD, EXP, RECIP, NORM} state_t;

  state_t                       state_q, state_d;
  logic [LW-1:0]                leff_q, leff_d;
  logic                         causal_q, causal_d;
  logic [CW-1:0]                row_q, row_d;
  logic [CW-1:0]                col_q, col_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic [SUM_WIDTH-1:0]         sum_q, sum_d;
  logic [SUM_WIDTH-1:0]         quo_q, quo_d;
  logic [SUM_WIDTH-1:0]         rem_q, rem_d;
  logic [DIV_CW-1:0]            div_cnt_q, div_cnt_d;
  logic                         out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
  logic [CW-1:0]                out_col_q, out_col_d;
  logic                         out_last_q, out_last_d;
  logic                         row_done_q, row_done_d;

  logic [EXP_WIDTH-1:0]         mem_q [MAX_LEN];
  logic                         mem_we;
  logic [CW-1:0]                mem_wa;
  logic [EXP_WIDTH-1:0]         mem_wd;

  logic [LW-1:0]                leff_cfg;
  logic                         col_last, col_masked, norm_last;
  logic signed [DATA_WIDTH-1:0] x_rd;
  logic signed [DATA_WIDTH:0]   d_raw, d_sh;
  logic [EXP_WIDTH-1:0]         e_val;
  logic [SUM_WIDTH:0]           rem_sh;
  logic [CW-1:0]                norm_idx;
  logic [PW-1:0]                prod, prod_rnd, p_full;
  logic [DATA_WIDTH-1:0]        p_sat;

  // Table holds round(65535 * exp(d)), i.e. it is scaled for EXP_WIDTH = 16.
  function automatic logic [EXP_WIDTH-1:0] exp_lut(input logic signed [DATA_WIDTH:0] dv);
    logic [3:0] k;
    k = 4'(-dv);
    exp_lut = '0;
    if (dv >= -15) begin
      case (k)
        4'd0:    exp_lut = EXP_WIDTH'(65535);
        4'd1:    exp_lut = EXP_WIDTH'(24109);
        4'd2:    exp_lut = EXP_WIDTH'(8869);
        4'd3:    exp_lut = EXP_WIDTH'(3263);
        4'd4:    exp_lut = EXP_WIDTH'(1200);
        4'd5:    exp_lut = EXP_WIDTH'(442);
        4'd6:    exp_lut = EXP_WIDTH'(162);
        4'd7:    exp_lut = EXP_WIDTH'(60);
        4'd8:    exp_lut = EXP_WIDTH'(22);
        4'd9:    exp_lut = EXP_WIDTH'(8);
        4'd10:   exp_lut = EXP_WIDTH'(3);
        4'd11:   exp_lut = EXP_WIDTH'(1);
        default: exp_lut = '0;
      endcase
    end
  endfunction

  assign leff_cfg   = (cfg_len == '0 || cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
  assign col_last   = (LW'(col_q) == leff_q - LW'(1));
  assign col_masked = causal_q && (col_q > row_q);
  assign x_rd       = mem_q[col_q][DATA_WIDTH-1:0];
  assign d_raw      = {x_rd[DATA_WIDTH-1], x_rd} - {max_q[DATA_WIDTH-1], max_q};

`ifdef SOFTMAX_TEMP_SCALE_EN
  logic [2:0] shift_q, shift_d;
  assign d_sh = d_raw >>> shift_q;
`else
  assign d_sh = d_raw;
`endif

  assign e_val     = col_masked ? '0 : exp_lut(d_sh);
  assign rem_sh    = {rem_q, quo_q[SUM_WIDTH-1]};
  // Column 0 is fetched on NORM entry; afterwards the next column is pre-computed for the handshake.
  assign norm_idx  = out_valid_q ? out_col_q + 1'b1 : '0;
  assign norm_last = (LW'(norm_idx) == leff_q - LW'(1));
  assign prod      = PW'(mem_q[norm_idx]) * PW'(quo_q);
  assign prod_rnd  = prod + ROUND_HALF;
  assign p_full    = prod_rnd >> 24;
  assign p_sat     = (p_full > PW'(127)) ? DATA_WIDTH'(127) : p_full[DATA_WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    leff_d      = leff_q;
    causal_d    = causal_q;
    row_d       = row_q;
    col_d       = col_q;
    max_d       = max_q;
    sum_d       = sum_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    div_cnt_d   = div_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;
    row_done_d  = 1'b0;
    mem_we      = 1'b0;
    mem_wa      = col_q;
    mem_wd      = '0;
    in_ready    = 1'b0;
`ifdef SOFTMAX_TEMP_SCALE_EN
    shift_d     = shift_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          leff_d   = leff_cfg;
          causal_d = cfg_causal;
          row_d    = cfg_row;
`ifdef SOFTMAX_TEMP_SCALE_EN
          shift_d  = cfg_shift;
`endif
          mem_we   = 1'b1;
          mem_wa   = '0;
          mem_wd   = EXP_WIDTH'(in_data);
          max_d    = in_data;
          sum_d    = '0;
          if (leff_cfg == LW'(1)) begin
            col_d   = '0;
            state_d = EXP;
          end else begin
            col_d   = CW'(1);
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we = 1'b1;
          mem_wd = EXP_WIDTH'(in_data);
          if (!col_masked && $signed(in_data) > max_q) max_d = in_data;
          if (col_last) begin
            col_d   = '0;
            state_d = EXP;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      EXP: begin
        mem_we = 1'b1;
        mem_wd = e_val;
        sum_d  = sum_q + SUM_WIDTH'(e_val);
        if (col_last) begin
          rem_d     = '0;
          quo_d     = DIVIDEND;
          div_cnt_d = '0;
          state_d   = RECIP;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      RECIP: begin
        // quo_q shifts the dividend out while the quotient bits shift in behind it.
        if (rem_sh >= {1'b0, sum_q}) begin
          rem_d = SUM_WIDTH'(rem_sh - {1'b0, sum_q});
          quo_d = {quo_q[SUM_WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[SUM_WIDTH-1:0];
          quo_d = {quo_q[SUM_WIDTH-2:0], 1'b0};
        end
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == DIV_CW'(SUM_WIDTH - 1)) state_d = NORM;
      end
      NORM: begin
        if (!out_valid_q || out_ready) begin
          if (out_valid_q && out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            row_done_d  = 1'b1;
            state_d     = IDLE;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = p_sat;
            out_col_d   = norm_idx;
            out_last_d  = norm_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      leff_q      <= '0;
      causal_q    <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      max_q       <= '0;
      sum_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      div_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      row_done_q  <= 1'b0;
`ifdef SOFTMAX_TEMP_SCALE_EN
      shift_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      leff_q      <= leff_d;
      causal_q    <= causal_d;
      row_q       <= row_d;
      col_q       <= col_d;
      max_q       <= max_d;
      sum_q       <= sum_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      div_cnt_q   <= div_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
      row_done_q  <= row_done_d;
`ifdef SOFTMAX_TEMP_SCALE_EN
      shift_q     <= shift_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign row_done  = row_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_softmax_row_stream.sv
// tb/tb_softmax_row_stream.sv - scoreboard bench for softmax_row_stream
// Directed rows push expected beats; a negedge monitor pops and compares each accepted output beat.
module tb_softmax_row_stream;
  localparam int ML = 64;
  localparam int LW = 7;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_causal = 1'b0;
  logic [CW-1:0] cfg_row = '0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    out_data;
  logic [CW-1:0] out_col;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          row_done;

  softmax_row_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_len   (cfg_len),
    .cfg_causal(cfg_causal),
    .cfg_row   (cfg_row),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .row_done  (row_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [7:0]    data;
    logic [CW-1:0] col;
    logic          last;
    logic          stall;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   stall = 0;
  bit   done_pend = 1'b0;
  bit   lat_arm = 1'b0;
  int   lat_t0 = 0;
  int   lat_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_col"}, out_col, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_row_done"}, row_done, 0);
  endtask

  task automatic send_row(input int len_cfg, input bit causal, input int row,
                          input int vals[$], input int exps[$], input bit stall_c0, input bit chk_imm);
    int   leff;
    int   w;
    exp_t ent;
    leff = (len_cfg < 1 || len_cfg > ML) ? ML : len_cfg;
    for (int c = 0; c < leff; c++) begin
      ent.data  = 8'(exps[c]);
      ent.col   = CW'(c);
      ent.last  = (c == leff - 1);
      ent.stall = stall_c0 && (c == 0);
      sb.push_back(ent);
    end
    cfg_len    = LW'(len_cfg);
    cfg_causal = causal;
    cfg_row    = CW'(row);
    for (int i = 0; i < leff; i++) begin
      in_data  = 8'(vals[i]);
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        chk("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      if (i == 0) begin
        if (chk_imm) chk("accept_with_row_done", row_done, 1);
        lat_t0  = cyc;
        lat_exp = 2 * leff + 33;
        lat_arm = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t f;
    if (rst_n) begin
      out_ready = (stall == 0);
      if (stall > 0) stall--;
      chk("row_done", row_done, done_pend);
      if (done_pend) chk("in_ready_after_done", in_ready, 1);
      done_pend = 1'b0;
      if (out_valid) begin
        if (lat_arm) begin
          chk("first_out_latency", cyc - lat_t0, lat_exp);
          lat_arm = 1'b0;
        end
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          f = sb[0];
          chk("out_data", out_data, f.data);
          chk("out_col", out_col, f.col);
          chk("out_last", out_last, f.last);
          if (out_ready) begin
            void'(sb.pop_front());
            if (f.last) done_pend = 1'b1;
            if (f.stall) stall = 5;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int v[$];
    int e[$];
    int w;
    rst_n = 1'b0;
    #12;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Partial row then asynchronous reset mid-LOAD; nothing is expected from it.
    cfg_len  = LW'(8);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(i + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("busy_mid_load", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("mid_load");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    v = '{5};                 e = '{127};
    send_row(1, 0, 0, v, e, 0, 0);
    v = '{3, 3};              e = '{63, 63};
    send_row(2, 0, 0, v, e, 0, 0);
    v = '{0, 0, 0, 0};        e = '{32, 32, 32, 32};
    send_row(4, 0, 0, v, e, 0, 0);
    v = '{0, 0, 9, 9};        e = '{63, 63, 0, 0};
    send_row(4, 1, 1, v, e, 0, 0);
    v = '{-128, 127, 0};      e = '{0, 127, 0};
    send_row(3, 0, 0, v, e, 0, 0);
    v = '{0, -1};             e = '{93, 34};
    send_row(2, 0, 0, v, e, 0, 0);
    v = '{7, 7, 7, 7};        e = '{32, 32, 32, 32};
    send_row(4, 0, 0, v, e, 1, 0);
    v.delete();
    e.delete();
    for (int i = 0; i < ML; i++) begin
      v.push_back(0);
      e.push_back(2);
    end
    send_row(0, 0, 0, v, e, 0, 1);

    w = 0;
    while ((sb.size() != 0 || busy) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    chk("idle_at_end", busy, 0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
